// File: rtl/div_pkg.sv
// Shared definitions for the carry-select restoring divider.
//   div_state_e : FSM state encoding (IDLE, BUSY, DONE)
//   DEF_WIDTH   : default operand / result width
//   DEF_BLOCK   : default carry-select block width
//   cnt_width() : width of an iteration counter that must hold the value WIDTH
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_BLOCK = 4;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/csel_subtractor.sv
// Combinational carry-select subtractor: diff = a + ~b + 1 (mod 2^N).
// Ports:
//   a, b  [N-1:0] in  : minuend, subtrahend
//   diff  [N-1:0] out : a - b modulo 2^N
//   cout          out : 1 when no borrow occurred (a >= b, unsigned)
// Each BLOCK-wide slice precomputes its sum for carry-in 0 and 1; the carry
// out of the previous slice picks one, so only one block ripples per path.
// The last slice is narrower when N is not a multiple of BLOCK.
module csel_subtractor #(
  parameter int N     = 9,
  parameter int BLOCK = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         cout
);

  localparam int NB = (N + BLOCK - 1) / BLOCK;

  logic [N-1:0] b_inv;
  logic [NB:0]  carry;

  assign b_inv    = ~b;
  // The "+1" of the two's-complement negation enters as the first carry-in.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < NB; i++) begin : g_blk
    localparam int LO = i * BLOCK;
    localparam int W  = ((N - LO) < BLOCK) ? (N - LO) : BLOCK;

    logic [W:0] sum0;
    logic [W:0] sum1;

    assign sum0 = {1'b0, a[LO +: W]} + {1'b0, b_inv[LO +: W]};
    assign sum1 = {1'b0, a[LO +: W]} + {1'b0, b_inv[LO +: W]} + (W + 1)'(1);

    assign diff[LO +: W] = carry[i] ? sum1[W-1:0] : sum0[W-1:0];
    assign carry[i+1]    = carry[i] ? sum1[W]     : sum0[W];
  end

  assign cout = carry[NB];

endmodule

// File: rtl/csel_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   start             : request; accepted only in IDLE or DONE
//   dividend, divisor : operands, sampled with an accepted start
//   busy              : high while iterating
//   done              : one-cycle pulse when a new result is presented
//   quotient,
//   remainder         : result, held until the next result is produced
//   div_by_zero       : set with the result when the divisor was zero
// A zero divisor short-circuits to DONE with quotient all ones and
// remainder equal to the dividend.
module csel_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic [WIDTH:0]   r_iter;
  logic [WIDTH-1:0] q_iter;

  assign accept    = start && (state_q != BUSY);
  assign last_iter = (cnt_q == CW'(1));

  // Bring the next dividend bit into the partial remainder.
  assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  csel_subtractor #(
    .N     (WIDTH + 1),
    .BLOCK (BLOCK)
  ) u_sub (
    .a    (r_shift),
    .b    ({1'b0, dvs_q}),
    .diff (trial),
    .cout (no_borrow)
  );

  // Restore on borrow: keep the shifted remainder and record a 0 bit.
  assign r_iter = no_borrow ? trial : r_shift;
  assign q_iter = {q_q[WIDTH-2:0], no_borrow};

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (divisor == '0) ? DONE : BUSY;
        else       state_d = IDLE;
      end
      BUSY:    if (last_iter) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    cnt_d = cnt_q;
    r_d   = r_q;
    q_d   = q_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    if (accept) begin
      q_d   = dividend;
      dvs_d = divisor;
      r_d   = '0;
      cnt_d = CW'(WIDTH);
      if (divisor == '0) begin
        quo_d = '1;
        rem_d = dividend;
        dbz_d = 1'b1;
      end
    end else if (state_q == BUSY) begin
      q_d   = q_iter;
      r_d   = r_iter;
      cnt_d = cnt_q - CW'(1);
      // Publish on the edge that enters DONE so results align with done.
      if (last_iter) begin
        quo_d = q_iter;
        rem_d = r_iter[WIDTH-1:0];
        dbz_d = 1'b0;
      end
    end
  end

  // Outputs.
  always_comb begin
    busy        = (state_q == BUSY);
    done        = (state_q == DONE);
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_csel_restoring_divider.sv
module tb_csel_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  // Last result the DUT should be presenting (reference model state).
  int prev_q   = 0;
  int prev_r   = 0;
  int prev_dbz = 0;

  csel_restoring_divider #(.WIDTH(W), .BLOCK(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, zero divisor yields all ones / dividend.
  function automatic int model_q(input int a, input int b);
    return (b == 0) ? ((1 << W) - 1) : (a / b);
  endfunction

  function automatic int model_r(input int a, input int b);
    return (b == 0) ? a : (a % b);
  endfunction

  // One complete request from IDLE; checks timing, hold behaviour and result.
  task automatic do_div(input int a, input int b);
    int lat;
    lat      = (b == 0) ? 1 : W + 1;
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    for (int c = 1; c <= lat; c++) begin
      if (c < lat) begin
        chk("busy_during", busy, 1);
        chk("done_early", done, 0);
        if (c == 1) chk("hold_q", quotient, prev_q);
      end else begin
        chk("done_at_lat", done, 1);
        chk("busy_at_done", busy, 0);
        chk("quotient", quotient, model_q(a, b));
        chk("remainder", remainder, model_r(a, b));
        chk("div_by_zero", div_by_zero, (b == 0) ? 1 : 0);
      end
      if (c < lat) tick();
    end
    prev_q   = model_q(a, b);
    prev_r   = model_r(a, b);
    prev_dbz = (b == 0) ? 1 : 0;
    tick();
    chk("done_one_cycle", done, 0);
    chk("hold_r_after", remainder, prev_r);
  endtask

  initial begin
    int dones;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state and quiet idle.
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dones++;
    end
    chk("idle_no_done", dones, 0);

    // Main case and boundaries.
    do_div(100, 7);
    do_div(255, 1);
    do_div(5, 9);
    do_div(255, 255);
    do_div(128, 16);

    // Divide by zero followed by a normal request.
    do_div(200, 0);
    do_div(9, 3);

    // Start pulsed during BUSY is ignored.
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        dividend = 8'd50; divisor = 8'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        chk("ign_done_cycle", c, 9);
        chk("ign_q", quotient, 14);
        chk("ign_r", remainder, 2);
      end
      tick();
    end
    start = 1'b0;
    chk("ign_single_done", dones, 1);
    prev_q = 14; prev_r = 2; prev_dbz = 0;

    // Start held through DONE: back-to-back results.
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    tick();
    dividend = 8'd50; divisor = 8'd5;
    for (int c = 1; c <= 18; c++) begin
      if (c == 10) start = 1'b0;
      if (c == 9 || c == 18) begin
        chk("b2b_done", done, 1);
        chk("b2b_q", quotient, (c == 9) ? 14 : 10);
        chk("b2b_r", remainder, (c == 9) ? 2 : 0);
      end else begin
        chk("b2b_busy", busy, 1);
        chk("b2b_nodone", done, 0);
        if (c == 12) chk("b2b_hold", quotient, 14);
      end
      if (c < 18) tick();
    end
    tick();
    chk("b2b_end", done, 0);
    prev_q = 10; prev_r = 0; prev_dbz = 0;

    // Reset mid-operation.
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dones++;
      tick();
    end
    chk("abort_no_done", dones, 0);
    prev_q = 0; prev_r = 0; prev_dbz = 0;
    do_div(81, 9);

    // Randomized requests, some with a zero divisor.
    for (int i = 0; i < 30; i++) begin
      int a, b;
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      do_div(a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
